// File: rtl/pipe_front_regs_if.sv
// Bus between the fetch/decode/execute datapath plus hazard unit (master) and the
// front-end stage register bank (slave). Counter signals exist only with PIPE_PERF_CNT_EN.
interface pipe_front_regs_if #(
    parameter int CTRL_W = 16
);
    logic [31:0]       pc_next;
    logic              pc_wr;
    logic              if_id_wr;
    logic              clear0;
    logic              clear1;
    logic [31:0]       if_instr;
    logic [CTRL_W-1:0] id_ctrl;
    logic [4:0]        id_rs;
    logic [4:0]        id_rt;
    logic [4:0]        id_rd;
    logic [CTRL_W-1:0] ex_ctrl_in;

    logic [31:0]       pc;
    logic [31:0]       if_id_instr;
    logic [31:0]       if_id_pc4;
    logic              if_id_valid;
    logic              id_ex_valid;
    logic              ex_ma_valid;
    logic [CTRL_W-1:0] id_ex_ctrl;
    logic [4:0]        id_ex_rs;
    logic [4:0]        id_ex_rt;
    logic [4:0]        id_ex_rd;
    logic [CTRL_W-1:0] ex_ma_ctrl;
`ifdef PIPE_PERF_CNT_EN
    logic [31:0]       stall_cnt;
    logic [31:0]       flush_cnt;
`endif

    modport master (
        output pc_next, pc_wr, if_id_wr, clear0, clear1,
        output if_instr, id_ctrl, id_rs, id_rt, id_rd, ex_ctrl_in,
        input  pc, if_id_instr, if_id_pc4, if_id_valid, id_ex_valid, ex_ma_valid,
        input  id_ex_ctrl, id_ex_rs, id_ex_rt, id_ex_rd, ex_ma_ctrl
`ifdef PIPE_PERF_CNT_EN
        , input stall_cnt, flush_cnt
`endif
    );

    modport slave (
        input  pc_next, pc_wr, if_id_wr, clear0, clear1,
        input  if_instr, id_ctrl, id_rs, id_rt, id_rd, ex_ctrl_in,
        output pc, if_id_instr, if_id_pc4, if_id_valid, id_ex_valid, ex_ma_valid,
        output id_ex_ctrl, id_ex_rs, id_ex_rt, id_ex_rd, ex_ma_ctrl
`ifdef PIPE_PERF_CNT_EN
        , output stall_cnt, flush_cnt
`endif
    );
endinterface

// File: rtl/pipe_front_regs.sv
// PC, IF/ID, ID/EX and EX/MA registers with valid bits; applies stall/flush controls.
// Optional stall/flush performance counters are built when PIPE_PERF_CNT_EN is defined.
module pipe_front_regs #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CTRL_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    pipe_front_regs_if.slave  bus
);
    logic [31:0]       r_pc;
    logic [31:0]       r_if_id_instr;
    logic [31:0]       r_if_id_pc4;
    logic              r_if_id_valid;
    logic [CTRL_W-1:0] r_id_ex_ctrl;
    logic [4:0]        r_id_ex_rs;
    logic [4:0]        r_id_ex_rt;
    logic [4:0]        r_id_ex_rd;
    logic              r_id_ex_valid;
    logic [CTRL_W-1:0] r_ex_ma_ctrl;
    logic              r_ex_ma_valid;

    logic [31:0]       w_pc4;
    logic              w_kill_if_id;
    logic              w_load_if_id;
    logic              w_bubble_id_ex;
    logic              w_kill_ex_ma;

    // Priority clear1 > clear0 > stall > normal; a stalled ID/EX takes a bubble so the
    // held IF/ID instruction is not issued twice.
    always_comb begin
        w_pc4          = r_pc + 32'd4;
        w_kill_if_id   = bus.clear1;
        w_load_if_id   = !bus.clear1 && bus.if_id_wr;
        w_bubble_id_ex = bus.clear1 || bus.clear0 || !bus.if_id_wr;
        w_kill_ex_ma   = bus.clear1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc          <= RESET_PC;
            r_if_id_instr <= '0;
            r_if_id_pc4   <= '0;
            r_if_id_valid <= 1'b0;
            r_id_ex_ctrl  <= '0;
            r_id_ex_rs    <= '0;
            r_id_ex_rt    <= '0;
            r_id_ex_rd    <= '0;
            r_id_ex_valid <= 1'b0;
            r_ex_ma_ctrl  <= '0;
            r_ex_ma_valid <= 1'b0;
        end else begin
            // PC: redirect target comes in through pc_next, so clear1 never gates pc_wr
            if (bus.pc_wr) begin
                r_pc <= bus.pc_next;
            end

            // IF/ID
            if (w_kill_if_id) begin
                r_if_id_instr <= '0;
                r_if_id_pc4   <= '0;
                r_if_id_valid <= 1'b0;
            end else if (w_load_if_id) begin
                r_if_id_instr <= bus.if_instr;
                r_if_id_pc4   <= w_pc4;
                r_if_id_valid <= 1'b1;
            end

            // ID/EX
            if (w_bubble_id_ex) begin
                r_id_ex_ctrl  <= '0;
                r_id_ex_rs    <= '0;
                r_id_ex_rt    <= '0;
                r_id_ex_rd    <= '0;
                r_id_ex_valid <= 1'b0;
            end else begin
                r_id_ex_ctrl  <= bus.id_ctrl;
                r_id_ex_rs    <= bus.id_rs;
                r_id_ex_rt    <= bus.id_rt;
                r_id_ex_rd    <= bus.id_rd;
                r_id_ex_valid <= r_if_id_valid;
            end

            // EX/MA
            if (w_kill_ex_ma) begin
                r_ex_ma_ctrl  <= '0;
                r_ex_ma_valid <= 1'b0;
            end else begin
                r_ex_ma_ctrl  <= bus.ex_ctrl_in;
                r_ex_ma_valid <= r_id_ex_valid;
            end
        end
    end

    assign bus.pc          = r_pc;
    assign bus.if_id_instr = r_if_id_instr;
    assign bus.if_id_pc4   = r_if_id_pc4;
    assign bus.if_id_valid = r_if_id_valid;
    assign bus.id_ex_ctrl  = r_id_ex_ctrl;
    assign bus.id_ex_rs    = r_id_ex_rs;
    assign bus.id_ex_rt    = r_id_ex_rt;
    assign bus.id_ex_rd    = r_id_ex_rd;
    assign bus.id_ex_valid = r_id_ex_valid;
    assign bus.ex_ma_ctrl  = r_ex_ma_ctrl;
    assign bus.ex_ma_valid = r_ex_ma_valid;

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;
    logic        w_stall_evt;
    logic        w_flush_evt;

    // A stall cycle that is also a redirect counts only as a flush
    always_comb begin
        w_stall_evt = !bus.if_id_wr && !bus.clear1;
        w_flush_evt = bus.clear1 || bus.clear0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall_evt) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (w_flush_evt) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
        end
    end

    assign bus.stall_cnt = r_stall_cnt;
    assign bus.flush_cnt = r_flush_cnt;
`endif
endmodule

// File: tb/tb_pipe_front_regs.sv
// Self-checking bench for pipe_front_regs: directed scenarios plus randomized control
// traffic against a slot-level reference model. Counter checks need PIPE_PERF_CNT_EN.
module tb_pipe_front_regs;
    localparam int          CTRL_W   = 16;
    localparam logic [31:0] RESET_PC = 32'h0040_0000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe_front_regs_if #(.CTRL_W(CTRL_W)) bus ();

    pipe_front_regs #(.RESET_PC(RESET_PC), .CTRL_W(CTRL_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic              valid;
        logic [31:0]       instr;
        logic [31:0]       pc4;
        logic [CTRL_W-1:0] ctrl;
        logic [4:0]        rs;
        logic [4:0]        rt;
        logic [4:0]        rd;
    } slot_t;

    logic [31:0] m_pc;
    slot_t       m_ifid, m_idex, m_exma;
    logic [31:0] m_stall, m_flush;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic slot_t bubble_slot();
        slot_t s;
        s.valid = 1'b0; s.instr = '0; s.pc4 = '0; s.ctrl = '0;
        s.rs = '0; s.rt = '0; s.rd = '0;
        return s;
    endfunction

    function automatic logic [31:0] instr_at(input logic [31:0] pc);
        return {pc[15:0] ^ 16'hBEEF, pc[15:0] ^ 16'h1357};
    endfunction

    function automatic logic [CTRL_W-1:0] ctrl_of(input logic [31:0] instr);
        return instr[31:16] ^ {instr[7:0], instr[15:8]};
    endfunction

    // Reference model: each stage is a slot that either takes the upstream slot, keeps
    // its own, or becomes a bubble, decided by the controls seen at this edge.
    task automatic model_edge();
        slot_t n_ifid, n_idex, n_exma;
        if (rst) begin
            m_pc = RESET_PC;
            m_ifid = bubble_slot(); m_idex = bubble_slot(); m_exma = bubble_slot();
            m_stall = '0; m_flush = '0;
            return;
        end
        n_ifid = m_ifid;
        if (bus.clear1) n_ifid = bubble_slot();
        else if (bus.if_id_wr) begin
            n_ifid = bubble_slot();
            n_ifid.valid = 1'b1; n_ifid.instr = bus.if_instr; n_ifid.pc4 = m_pc + 32'd4;
        end
        n_idex = bubble_slot();
        if (!(bus.clear1 || bus.clear0 || !bus.if_id_wr)) begin
            n_idex.valid = m_ifid.valid; n_idex.ctrl = bus.id_ctrl;
            n_idex.rs = bus.id_rs; n_idex.rt = bus.id_rt; n_idex.rd = bus.id_rd;
        end
        n_exma = bubble_slot();
        if (!bus.clear1) begin
            n_exma.valid = m_idex.valid; n_exma.ctrl = bus.ex_ctrl_in;
        end
        if (!bus.if_id_wr && !bus.clear1) m_stall = m_stall + 32'd1;
        if (bus.clear1 || bus.clear0) m_flush = m_flush + 32'd1;
        if (bus.pc_wr) m_pc = bus.pc_next;
        m_ifid = n_ifid; m_idex = n_idex; m_exma = n_exma;
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_datapath();
        logic [31:0] ins;
        ins = m_ifid.instr;
        bus.if_instr   = instr_at(m_pc);
        bus.id_ctrl    = ctrl_of(ins);
        bus.id_rs      = ins[25:21];
        bus.id_rt      = ins[20:16];
        bus.id_rd      = ins[15:11];
        bus.ex_ctrl_in = m_idex.ctrl;
    endtask

    task automatic set_idle();
        rst = 1'b0;
        bus.pc_wr = 1'b1; bus.if_id_wr = 1'b1; bus.clear0 = 1'b0; bus.clear1 = 1'b0;
        bus.pc_next = m_pc + 32'd4;
        drive_datapath();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.pc_wr = 1'b1; bus.if_id_wr = 1'b1; bus.clear0 = 1'b0; bus.clear1 = 1'b0;
        bus.pc_next = 32'hDEAD_BEE0; bus.if_instr = 32'h1234_5678;
        bus.id_ctrl = 16'hFFFF; bus.id_rs = 5'd1; bus.id_rt = 5'd2; bus.id_rd = 5'd3;
        bus.ex_ctrl_in = 16'hFFFF;
        step();
        n_checks++;
        if (bus.pc !== 32'h0040_0000) begin
            n_fail++; $display("FAIL reset_pc: got %h expected %h", bus.pc, 32'h0040_0000);
        end
        n_checks++;
        if ({bus.if_id_valid, bus.id_ex_valid, bus.ex_ma_valid} !== 3'b000) begin
            n_fail++; $display("FAIL reset_valid: got %b expected 000",
                               {bus.if_id_valid, bus.id_ex_valid, bus.ex_ma_valid});
        end
        n_checks++;
        if ({bus.id_ex_ctrl, bus.ex_ma_ctrl, bus.if_id_instr} !== '0) begin
            n_fail++; $display("FAIL reset_ctrl: got %h %h %h expected 0",
                               bus.id_ex_ctrl, bus.ex_ma_ctrl, bus.if_id_instr);
        end
`ifdef PIPE_PERF_CNT_EN
        n_checks++;
        if ({bus.stall_cnt, bus.flush_cnt} !== 64'd0) begin
            n_fail++; $display("FAIL reset_cnt: got %0d %0d expected 0 0", bus.stall_cnt, bus.flush_cnt);
        end
`endif
    endtask

    task automatic test_straight_line();
        logic [31:0] i0;
        logic [CTRL_W-1:0] c0;
        i0 = instr_at(32'h0040_0000);
        c0 = ctrl_of(i0);
        set_idle(); step();
        n_checks++;
        if ({bus.if_id_valid, bus.if_id_instr, bus.if_id_pc4, bus.pc} !==
            {1'b1, i0, 32'h0040_0004, 32'h0040_0004}) begin
            n_fail++; $display("FAIL fetch: got v=%b i=%h pc4=%h pc=%h expected v=1 i=%h pc4=00400004 pc=00400004",
                               bus.if_id_valid, bus.if_id_instr, bus.if_id_pc4, bus.pc, i0);
        end
        set_idle(); step();
        n_checks++;
        if ({bus.id_ex_valid, bus.id_ex_ctrl, bus.id_ex_rs, bus.id_ex_rt, bus.id_ex_rd} !==
            {1'b1, c0, i0[25:21], i0[20:16], i0[15:11]}) begin
            n_fail++; $display("FAIL decode_stage: got v=%b c=%h rs=%0d rt=%0d rd=%0d expected v=1 c=%h rs=%0d rt=%0d rd=%0d",
                               bus.id_ex_valid, bus.id_ex_ctrl, bus.id_ex_rs, bus.id_ex_rt, bus.id_ex_rd,
                               c0, i0[25:21], i0[20:16], i0[15:11]);
        end
        set_idle(); step();
        n_checks++;
        if ({bus.ex_ma_valid, bus.ex_ma_ctrl} !== {1'b1, c0}) begin
            n_fail++; $display("FAIL ex_ma_arrival: got v=%b c=%h expected v=1 c=%h",
                               bus.ex_ma_valid, bus.ex_ma_ctrl, c0);
        end
        set_idle(); step();
        n_checks++;
        if (bus.pc !== 32'h0040_0010) begin
            n_fail++; $display("FAIL straight_pc: got %h expected 00400010", bus.pc);
        end
    endtask

    task automatic test_load_use();
        logic [31:0] pc_b, ins_b, st_b;
        logic        idv_b;
        pc_b = m_pc; ins_b = m_ifid.instr; idv_b = m_idex.valid; st_b = m_stall;
        set_idle();
        bus.pc_wr = 1'b0; bus.if_id_wr = 1'b0;
        step();
        n_checks++;
        if ({bus.pc, bus.if_id_instr} !== {pc_b, ins_b}) begin
            n_fail++; $display("FAIL load_use_hold: got pc=%h i=%h expected pc=%h i=%h",
                               bus.pc, bus.if_id_instr, pc_b, ins_b);
        end
        n_checks++;
        if ({bus.id_ex_valid, bus.id_ex_ctrl, bus.ex_ma_valid} !== {1'b0, {CTRL_W{1'b0}}, idv_b}) begin
            n_fail++; $display("FAIL load_use_bubble: got idv=%b c=%h emv=%b expected idv=0 c=0 emv=%b",
                               bus.id_ex_valid, bus.id_ex_ctrl, bus.ex_ma_valid, idv_b);
        end
`ifdef PIPE_PERF_CNT_EN
        n_checks++;
        if (bus.stall_cnt !== st_b + 32'd1) begin
            n_fail++; $display("FAIL load_use_cnt: got %0d expected %0d", bus.stall_cnt, st_b + 32'd1);
        end
`endif
    endtask

    task automatic test_branch();
        logic [31:0] fl_b;
        fl_b = m_flush;
        set_idle();
        bus.clear1 = 1'b1; bus.pc_next = 32'h0040_0100;
        step();
        n_checks++;
        if ({bus.if_id_valid, bus.id_ex_valid, bus.ex_ma_valid, bus.pc} !== {3'b000, 32'h0040_0100}) begin
            n_fail++; $display("FAIL branch_flush: got v=%b%b%b pc=%h expected v=000 pc=00400100",
                               bus.if_id_valid, bus.id_ex_valid, bus.ex_ma_valid, bus.pc);
        end
`ifdef PIPE_PERF_CNT_EN
        n_checks++;
        if (bus.flush_cnt !== fl_b + 32'd1) begin
            n_fail++; $display("FAIL branch_cnt: got %0d expected %0d", bus.flush_cnt, fl_b + 32'd1);
        end
`endif
        set_idle(); step();
        n_checks++;
        if ({bus.if_id_valid, bus.if_id_instr} !== {1'b1, instr_at(32'h0040_0100)}) begin
            n_fail++; $display("FAIL branch_target: got v=%b i=%h expected v=1 i=%h",
                               bus.if_id_valid, bus.if_id_instr, instr_at(32'h0040_0100));
        end
    endtask

    task automatic test_clear1_with_stall();
        logic [31:0] st_b;
        set_idle(); step();
        set_idle(); step();
        st_b = m_stall;
        set_idle();
        bus.clear1 = 1'b1; bus.if_id_wr = 1'b0;
        step();
        n_checks++;
        if (bus.if_id_valid !== 1'b0) begin
            n_fail++; $display("FAIL clear1_over_stall: got if_id_valid=%b expected 0", bus.if_id_valid);
        end
`ifdef PIPE_PERF_CNT_EN
        n_checks++;
        if (bus.stall_cnt !== st_b) begin
            n_fail++; $display("FAIL clear1_stall_cnt: got %0d expected %0d", bus.stall_cnt, st_b);
        end
`endif
    endtask

    task automatic test_reset_mid_stall();
        set_idle(); step();
        set_idle(); step();
        set_idle(); bus.pc_wr = 1'b0; bus.if_id_wr = 1'b0; bus.clear0 = 1'b1;
        step();
        rst = 1'b1;
        step();
        n_checks++;
        if ({bus.pc, bus.if_id_valid, bus.id_ex_valid, bus.ex_ma_valid} !== {RESET_PC, 3'b000}) begin
            n_fail++; $display("FAIL reset_mid_stall: got pc=%h v=%b%b%b expected pc=%h v=000",
                               bus.pc, bus.if_id_valid, bus.id_ex_valid, bus.ex_ma_valid, RESET_PC);
        end
`ifdef PIPE_PERF_CNT_EN
        n_checks++;
        if ({bus.stall_cnt, bus.flush_cnt} !== 64'd0) begin
            n_fail++; $display("FAIL reset_mid_stall_cnt: got %0d %0d expected 0 0", bus.stall_cnt, bus.flush_cnt);
        end
`endif
        set_idle();
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 400; cyc++) begin
            set_idle();
            rst           = ($urandom_range(0, 59) == 0);
            bus.pc_wr     = ($urandom_range(0, 3) != 0);
            bus.if_id_wr  = ($urandom_range(0, 3) != 0);
            bus.clear0    = ($urandom_range(0, 7) == 0);
            bus.clear1    = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 4) == 0) bus.pc_next = {$urandom} & 32'hFFFF_FFFC;
            if ($urandom_range(0, 3) == 0) bus.ex_ctrl_in = CTRL_W'($urandom);
            if ($urandom_range(0, 3) == 0) bus.id_ctrl = CTRL_W'($urandom);
            step();
            n_checks++;
            if ({bus.pc, bus.if_id_valid, bus.if_id_instr, bus.if_id_pc4} !==
                {m_pc, m_ifid.valid, m_ifid.instr, m_ifid.pc4}) begin
                n_fail++; $display("FAIL rand_front cyc %0d: got pc=%h v=%b i=%h pc4=%h expected pc=%h v=%b i=%h pc4=%h",
                                   cyc, bus.pc, bus.if_id_valid, bus.if_id_instr, bus.if_id_pc4,
                                   m_pc, m_ifid.valid, m_ifid.instr, m_ifid.pc4);
            end
            n_checks++;
            if ({bus.id_ex_valid, bus.id_ex_ctrl, bus.id_ex_rs, bus.id_ex_rt, bus.id_ex_rd,
                 bus.ex_ma_valid, bus.ex_ma_ctrl} !==
                {m_idex.valid, m_idex.ctrl, m_idex.rs, m_idex.rt, m_idex.rd,
                 m_exma.valid, m_exma.ctrl}) begin
                n_fail++; $display("FAIL rand_back cyc %0d: got idv=%b c=%h %0d/%0d/%0d emv=%b c=%h expected idv=%b c=%h %0d/%0d/%0d emv=%b c=%h",
                                   cyc, bus.id_ex_valid, bus.id_ex_ctrl, bus.id_ex_rs, bus.id_ex_rt,
                                   bus.id_ex_rd, bus.ex_ma_valid, bus.ex_ma_ctrl,
                                   m_idex.valid, m_idex.ctrl, m_idex.rs, m_idex.rt, m_idex.rd,
                                   m_exma.valid, m_exma.ctrl);
            end
`ifdef PIPE_PERF_CNT_EN
            n_checks++;
            if ({bus.stall_cnt, bus.flush_cnt} !== {m_stall, m_flush}) begin
                n_fail++; $display("FAIL rand_cnt cyc %0d: got %0d %0d expected %0d %0d",
                                   cyc, bus.stall_cnt, bus.flush_cnt, m_stall, m_flush);
            end
`endif
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        m_pc = '0; m_stall = '0; m_flush = '0;
        m_ifid = bubble_slot(); m_idex = bubble_slot(); m_exma = bubble_slot();
        #2;
        test_reset();
        test_straight_line();
        test_load_use();
        test_branch();
        test_clear1_with_stall();
        test_reset_mid_stall();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
